// File: rtl/mac_seq_multiplier.sv
// Sequential shift-and-add multiplier with optional two's-complement operands.
// Accepts one multiply in IDLE, runs WIDTH add/shift steps, then publishes
// the product on P in FIN and pulses DONE/LOAD for one cycle.
// Handshake: START is honoured only in IDLE (BUSY=0); while BUSY=1 START is
// ignored. DONE/LOAD is a single-cycle strobe marking a fresh value on P.
module mac_seq_multiplier #(
  parameter int WIDTH = 8
) (
  input  logic                 CLK,
  input  logic                 R,
  input  logic                 START,
  input  logic                 SGN,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  output logic                 BUSY,
  output logic                 DONE,
  output logic                 LOAD,
  output logic [2*WIDTH-1:0]   P,
  output logic [1:0]           dbg_state_o
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t               state_q;
  logic [2*WIDTH-1:0]   mcand_q;
  logic [WIDTH-1:0]     mplier_q;
  logic [2*WIDTH-1:0]   prod_q;
  logic [CW-1:0]        cnt_q;
  logic                 neg_q;
  logic                 done_q;
  logic [2*WIDTH-1:0]   p_q;

  logic [WIDTH-1:0]     mag_a_d;
  logic [WIDTH-1:0]     mag_b_d;
  logic                 neg_d;
  logic [2*WIDTH-1:0]   prod_d;
  logic [2*WIDTH-1:0]   p_d;

  // Operand magnitudes and result sign; the most negative value maps to
  // 2^(WIDTH-1), which still fits as an unsigned WIDTH-bit magnitude.
  always_comb begin
    mag_a_d = A;
    mag_b_d = B;
    neg_d   = 1'b0;
    if (SGN) begin
      if (A[WIDTH-1]) mag_a_d = ~A + WIDTH'(1);
      if (B[WIDTH-1]) mag_b_d = ~B + WIDTH'(1);
      neg_d = A[WIDTH-1] ^ B[WIDTH-1];
    end
  end

  // Next partial product and the sign-corrected final product.
  always_comb begin
    prod_d = mplier_q[0] ? (prod_q + mcand_q) : prod_q;
    p_d    = neg_q ? (~prod_q + (2*WIDTH)'(1)) : prod_q;
  end

  // Control FSM and datapath registers; reset dominates START.
  always_ff @(posedge CLK) begin
    if (R) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      done_q   <= 1'b0;
      p_q      <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (START) begin
            mcand_q  <= {{WIDTH{1'b0}}, mag_a_d};
            mplier_q <= mag_b_d;
            prod_q   <= '0;
            cnt_q    <= '0;
            neg_q    <= neg_d;
            state_q  <= RUN;
          end
        end
        RUN: begin
          prod_q   <= prod_d;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + CW'(1);
          if (cnt_q == LAST_CNT) state_q <= FIN;
        end
        FIN: begin
          p_q     <= p_d;
          done_q  <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign BUSY        = (state_q != IDLE);
  assign DONE        = done_q;
  assign LOAD        = done_q;
  assign P           = p_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mac_seq_multiplier.sv
// Directed bench for mac_seq_multiplier (WIDTH=8) with hand-computed products.
module tb_mac_seq_multiplier;

  localparam int WIDTH = 8;
  localparam int LIMIT = 30;

  logic                 clk;
  logic                 r;
  logic                 start;
  logic                 sgn;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 busy;
  logic                 done;
  logic                 load;
  logic [2*WIDTH-1:0]   p;
  logic [1:0]           dbg_state;

  int n_checks;
  int n_fail;

  mac_seq_multiplier #(.WIDTH(WIDTH)) dut (
    .CLK         (clk),
    .R           (r),
    .START       (start),
    .SGN         (sgn),
    .A           (a),
    .B           (b),
    .BUSY        (busy),
    .DONE        (done),
    .LOAD        (load),
    .P           (p),
    .dbg_state_o (dbg_state)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Driver: present operands with START for one cycle (accepted on the next posedge).
  task automatic start_op(input logic s, input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv);
    start = 1'b1;
    sgn   = s;
    a     = av;
    b     = bv;
    @(negedge clk);
    start = 1'b0;
    // Scramble operands after acceptance; result must not depend on them.
    sgn   = ~s;
    a     = WIDTH'($urandom_range(0, 255));
    b     = WIDTH'($urandom_range(0, 255));
  endtask

  // Wait for DONE, checking latency, BUSY width, P hold and the result.
  // inject_k >= 0 pulses START (100*100) at that cycle while busy.
  // chain=1 raises START with the next operands during the DONE cycle.
  task automatic wait_result(input string tag, input logic [2*WIDTH-1:0] exp_p,
                             input int inject_k, input bit chain,
                             input logic cs, input logic [WIDTH-1:0] ca,
                             input logic [WIDTH-1:0] cb);
    int k;
    int busy_cnt;
    bit hold_ok;
    logic [2*WIDTH-1:0] prior;
    k = 0;
    busy_cnt = 0;
    hold_ok = 1'b1;
    prior = p;
    while (!done && k < LIMIT) begin
      if (busy) busy_cnt++;
      if (p !== prior) hold_ok = 1'b0;
      if (k == inject_k) begin
        start = 1'b1; a = 8'd100; b = 8'd100; sgn = 1'b0;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      k++;
    end
    start = 1'b0;
    check({tag, "_latency"}, k, WIDTH + 1);
    check({tag, "_busy_cycles"}, busy_cnt, WIDTH + 1);
    check({tag, "_p_hold"}, {31'd0, hold_ok}, 32'd1);
    check({tag, "_p"}, {16'd0, p}, {16'd0, exp_p});
    check({tag, "_load"}, {31'd0, load}, 32'd1);
    check({tag, "_busy_at_done"}, {31'd0, busy}, 32'd0);
    if (chain) begin
      start = 1'b1; sgn = cs; a = ca; b = cb;
    end
    @(negedge clk);
    if (chain) begin
      start = 1'b0;
      a = WIDTH'($urandom_range(0, 255));
      b = WIDTH'($urandom_range(0, 255));
      check({tag, "_chain_accepted"}, {31'd0, busy}, 32'd1);
    end
    check({tag, "_done_one_cycle"}, {31'd0, done}, 32'd0);
  endtask

  // Confirm no stray DONE for n cycles.
  task automatic expect_quiet(input string tag, input int n);
    int seen;
    seen = 0;
    for (int i = 0; i < n; i++) begin
      if (done || load) seen++;
      @(negedge clk);
    end
    check({tag, "_no_done"}, seen, 0);
    check({tag, "_idle"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int k;
    n_checks = 0;
    n_fail   = 0;
    r = 1'b1; start = 1'b0; sgn = 1'b0; a = '0; b = '0;

    // Reset
    repeat (3) @(negedge clk);
    check("rst_p", {16'd0, p}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_load", {31'd0, load}, 32'd0);
    check("rst_state", {30'd0, dbg_state}, 32'd0);
    // Reset dominates START
    start = 1'b1; a = 8'd5; b = 8'd5;
    @(negedge clk);
    start = 1'b0;
    check("rst_prio_busy", {31'd0, busy}, 32'd0);
    r = 1'b0;
    @(negedge clk);

    // Unsigned
    start_op(1'b0, 8'd13, 8'd11);
    wait_result("u13x11", 16'd143, -1, 1'b0, 1'b0, '0, '0);
    start_op(1'b0, 8'd255, 8'd255);
    wait_result("u255x255", 16'hFE01, -1, 1'b0, 1'b0, '0, '0);
    start_op(1'b0, 8'h80, 8'd2);
    wait_result("u128x2", 16'h0100, -1, 1'b0, 1'b0, '0, '0);

    // Signed
    start_op(1'b1, 8'hF9, 8'd9);
    wait_result("s_m7x9", 16'hFFC1, -1, 1'b0, 1'b0, '0, '0);
    start_op(1'b1, 8'h80, 8'h80);
    wait_result("s_m128xm128", 16'h4000, -1, 1'b0, 1'b0, '0, '0);
    start_op(1'b1, 8'd0, 8'hFF);
    wait_result("s_0xm1", 16'h0000, -1, 1'b0, 1'b0, '0, '0);
    start_op(1'b1, 8'hFF, 8'hFF);
    wait_result("s_m1xm1", 16'h0001, -1, 1'b0, 1'b0, '0, '0);
    start_op(1'b1, 8'd127, 8'h80);
    wait_result("s_127xm128", 16'hC080, -1, 1'b0, 1'b0, '0, '0);

    // START while busy is ignored
    start_op(1'b0, 8'd3, 8'd5);
    wait_result("busy_ignore", 16'd15, 2, 1'b0, 1'b0, '0, '0);
    expect_quiet("busy_ignore", 15);

    // Reset in the 4th RUN cycle
    start_op(1'b0, 8'd13, 8'd11);
    k = 0;
    while (k < 3) begin
      @(negedge clk);
      k++;
    end
    r = 1'b1;
    @(negedge clk);
    r = 1'b0;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_p", {16'd0, p}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    expect_quiet("abort", 15);
    start_op(1'b0, 8'd2, 8'd3);
    wait_result("post_abort", 16'd6, -1, 1'b0, 1'b0, '0, '0);

    // Back-to-back
    start_op(1'b0, 8'd3, 8'd5);
    wait_result("b2b_first", 16'd15, -1, 1'b1, 1'b0, 8'd10, 8'd10);
    wait_result("b2b_second", 16'd100, -1, 1'b0, 1'b0, '0, '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
